// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way cache level.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_RESP,
        S_INV_LOOKUP,
        S_INV_WB
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Set index = low idx_w bits of the word address
    function automatic int unsigned addr_idx(input logic [31:0] addr, input int idx_w);
        return int'(addr & ((32'd1 << idx_w) - 32'd1));
    endfunction

    // Tag = address bits above the index
    function automatic int unsigned addr_tag(input logic [31:0] addr, input int idx_w);
        return int'(addr >> idx_w);
    endfunction

endpackage

// File: rtl/cache_level_nway_if.sv
// Bundles the upstream, downstream and back-invalidate ports of one cache level.
// Latency: none (wiring only).
// Backpressure: req/ack style on every leg; see the cache for timing.
interface cache_level_nway_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              up_req;
    logic              up_we;
    logic [ADDR_W-1:0] up_addr;
    logic [DATA_W-1:0] up_wdata;
    logic              up_ready;
    logic [DATA_W-1:0] up_rdata;
    logic              up_hit;

    logic              dn_req;
    logic              dn_we;
    logic [ADDR_W-1:0] dn_addr;
    logic [DATA_W-1:0] dn_wdata;
    logic              dn_ack;
    logic [DATA_W-1:0] dn_rdata;

    logic              inv_req;
    logic [ADDR_W-1:0] inv_addr;
    logic              inv_ack;

    // The cache itself
    modport slave (
        input  up_req, up_we, up_addr, up_wdata, dn_ack, dn_rdata, inv_req, inv_addr,
        output up_ready, up_rdata, up_hit, dn_req, dn_we, dn_addr, dn_wdata, inv_ack
    );

    // The environment around it (requester, next level, invalidator)
    modport master (
        output up_req, up_we, up_addr, up_wdata, dn_ack, dn_rdata, inv_req, inv_addr,
        input  up_ready, up_rdata, up_hit, dn_req, dn_we, dn_addr, dn_wdata, inv_ack
    );
endinterface

// File: rtl/cache_level_nway_lru_ages.sv
// Per-set age-based LRU: ages form a permutation of 0..WAYS-1, highest age is the victim.
// Latency: update takes effect on the next edge; victim lookup is combinational.
// Backpressure: none; accepts an update every cycle.
module cache_lru_ages
    import cache_pkg::*;
#(
    parameter  int SETS  = 4,
    parameter  int WAYS  = 2,
    localparam int IDX_W = clog2(SETS),
    localparam int AGE_W = clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [IDX_W-1:0] upd_set,
    input  logic [AGE_W-1:0] upd_way,
    input  logic [IDX_W-1:0] vic_set,
    output logic [AGE_W-1:0] vic_way
);
    logic [AGE_W-1:0] age [SETS][WAYS];

    // Touched way becomes youngest; ways younger than it age by one
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= AGE_W'(w);
                end
            end
        end else if (upd) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == upd_way) begin
                    age[upd_set][w] <= '0;
                end else if (age[upd_set][w] < age[upd_set][upd_way]) begin
                    age[upd_set][w] <= age[upd_set][w] + 1'b1;
                end
            end
        end
    end

    // Victim is the way holding the oldest age in the set
    always_comb begin
        vic_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[vic_set][w] == AGE_W'(WAYS - 1)) begin
                vic_way = AGE_W'(w);
            end
        end
    end
endmodule

// File: rtl/cache_level_nway.sv
// N-way set-associative write-back/write-allocate cache level with back-invalidate.
// Latency: hit -> up_ready 2 cycles after acceptance; each WB/FILL leg adds its dn wait + 1.
// Backpressure: one transaction at a time; requests are only sampled in IDLE, dn_req held until dn_ack.
module cache_level_nway
    import cache_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input logic              clk,
    input logic              rst,
    cache_level_nway_if.slave bus
);
    localparam int IDX_W = clog2(SETS);
    localparam int AGE_W = clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [WAYS-1:0]   vld  [SETS];
    logic [WAYS-1:0]   drt  [SETS];
    logic [TAG_W-1:0]  tags [SETS][WAYS];
    logic [DATA_W-1:0] data [SETS][WAYS];

    state_t            state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_hit;
    logic [AGE_W-1:0]  r_way;

    logic              up_ready_q, up_hit_q, dn_req_q, dn_we_q, inv_ack_q;
    logic [DATA_W-1:0] up_rdata_q, dn_wdata_q;
    logic [ADDR_W-1:0] dn_addr_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit_any, has_free;
    logic [AGE_W-1:0]  hit_way, free_way, lru_way, victim;

    assign idx = IDX_W'(addr_idx(32'(r_addr), IDX_W));
    assign tag = TAG_W'(addr_tag(32'(r_addr), IDX_W));

    assign bus.up_ready = up_ready_q;
    assign bus.up_rdata = up_rdata_q;
    assign bus.up_hit   = up_hit_q;
    assign bus.dn_req   = dn_req_q;
    assign bus.dn_we    = dn_we_q;
    assign bus.dn_addr  = dn_addr_q;
    assign bus.dn_wdata = dn_wdata_q;
    assign bus.inv_ack  = inv_ack_q;

    // Tag compare across the set and lowest-index free way (descending loop, last write wins)
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld[idx][w] && tags[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!vld[idx][w]) begin
                has_free = 1'b1;
                free_way = AGE_W'(w);
            end
        end
    end

    assign victim = has_free ? free_way : lru_way;

    // Every completed access passes through RESP exactly once, so age it there
    cache_lru_ages #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .clk     (clk),
        .rst     (rst),
        .upd     (state == S_RESP),
        .upd_set (idx),
        .upd_way (r_way),
        .vic_set (idx),
        .vic_way (lru_way)
    );

    // Control FSM with registered outputs and the line arrays
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            for (int s = 0; s < SETS; s++) begin
                vld[s] <= '0;
                drt[s] <= '0;
            end
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_hit      <= 1'b0;
            r_way      <= '0;
            up_ready_q <= 1'b0;
            up_rdata_q <= '0;
            up_hit_q   <= 1'b0;
            dn_req_q   <= 1'b0;
            dn_we_q    <= 1'b0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            inv_ack_q  <= 1'b0;
        end else begin
            up_ready_q <= 1'b0;
            inv_ack_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.inv_req) begin
                        r_addr <= bus.inv_addr;
                        state  <= S_INV_LOOKUP;
                    end else if (bus.up_req) begin
                        r_we    <= bus.up_we;
                        r_addr  <= bus.up_addr;
                        r_wdata <= bus.up_wdata;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_hit <= hit_any;
                    if (hit_any) begin
                        r_way <= hit_way;
                        if (r_we) begin
                            data[idx][hit_way] <= r_wdata;
                            drt[idx][hit_way]  <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        r_way <= victim;
                        if (vld[idx][victim] && drt[idx][victim]) begin
                            dn_req_q   <= 1'b1;
                            dn_we_q    <= 1'b1;
                            dn_addr_q  <= {tags[idx][victim], idx};
                            dn_wdata_q <= data[idx][victim];
                            state      <= S_WB;
                        end else if (!r_we) begin
                            dn_req_q  <= 1'b1;
                            dn_we_q   <= 1'b0;
                            dn_addr_q <= r_addr;
                            state     <= S_FILL;
                        end else begin
                            // Whole-line write: no fetch needed
                            tags[idx][victim] <= tag;
                            data[idx][victim] <= r_wdata;
                            vld[idx][victim]  <= 1'b1;
                            drt[idx][victim]  <= 1'b1;
                            state             <= S_RESP;
                        end
                    end
                end
                S_WB: begin
                    if (bus.dn_ack) begin
                        if (r_we) begin
                            tags[idx][r_way] <= tag;
                            data[idx][r_way] <= r_wdata;
                            vld[idx][r_way]  <= 1'b1;
                            drt[idx][r_way]  <= 1'b1;
                            dn_req_q         <= 1'b0;
                            state            <= S_RESP;
                        end else begin
                            // dn_req stays up; the next leg starts with the fill address
                            dn_we_q   <= 1'b0;
                            dn_addr_q <= r_addr;
                            state     <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (bus.dn_ack) begin
                        tags[idx][r_way] <= tag;
                        data[idx][r_way] <= bus.dn_rdata;
                        vld[idx][r_way]  <= 1'b1;
                        drt[idx][r_way]  <= 1'b0;
                        dn_req_q         <= 1'b0;
                        state            <= S_RESP;
                    end
                end
                S_RESP: begin
                    up_ready_q <= 1'b1;
                    up_rdata_q <= data[idx][r_way];
                    up_hit_q   <= r_hit;
                    state      <= S_IDLE;
                end
                S_INV_LOOKUP: begin
                    if (hit_any && drt[idx][hit_way]) begin
                        r_way      <= hit_way;
                        dn_req_q   <= 1'b1;
                        dn_we_q    <= 1'b1;
                        dn_addr_q  <= r_addr;
                        dn_wdata_q <= data[idx][hit_way];
                        state      <= S_INV_WB;
                    end else begin
                        if (hit_any) begin
                            vld[idx][hit_way] <= 1'b0;
                        end
                        inv_ack_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_INV_WB: begin
                    if (bus.dn_ack) begin
                        vld[idx][r_way] <= 1'b0;
                        drt[idx][r_way] <= 1'b0;
                        dn_req_q        <= 1'b0;
                        inv_ack_q       <= 1'b1;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
